// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps a 32-bit frequency word from a start to a stop value in
// fixed increments, holding each value for a programmable number of clocks.
// Feeds the freq_set input of the phase-accumulator clock divider.
module freq_sweep_ctrl #(
   parameter logic [31:0] CLKREF  = 32'd256_000_000,
   parameter int unsigned DWELL_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               loop_en,
   input  logic [31:0]        f_start,
   input  logic [31:0]        f_stop,
   input  logic [31:0]        f_step,
   input  logic [DWELL_W-1:0] dwell_cycles,
   output logic [31:0]        freq_set,
   output logic               busy,
   output logic               step_strobe,
   output logic               done
);

   // CLKREF only documents the reference clock shared with the divider.
   if (CLKREF == 32'd0) begin : g_clkref_unset
   end

   typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

   localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);

   state_e state_q, state_d;

   // Shadow copies of the sweep parameters, frozen at start.
   logic [31:0]        start_q, start_d;
   logic [31:0]        stop_q, stop_d;
   logic [31:0]        step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               loop_q, loop_d;
   logic               dir_up_q, dir_up_d;

   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [31:0]        freq_q, freq_d;
   logic               strobe_q, strobe_d;

   logic               start_go;
   logic               expired;
   logic               at_end;
   logic [DWELL_W-1:0] dwell_in;
   logic [32:0]        sum;
   logic [32:0]        diff;
   logic [31:0]        next_up;
   logic [31:0]        next_dn;
   logic [31:0]        next_freq;

   assign dwell_in = (dwell_cycles == '0) ? DwellOne : dwell_cycles;
   assign start_go = (state_q == StIdle) && start && !abort;
   // cnt_q counts down the remaining clocks of the current dwell.
   assign expired  = (cnt_q == '0);
   // A zero step can never reach f_stop, so it ends the sweep after one dwell.
   assign at_end   = (freq_q == stop_q) || (step_q == '0);

   // 33-bit arithmetic: carry or borrow clamps to f_stop so freq_set never wraps.
   assign sum       = {1'b0, freq_q} + {1'b0, step_q};
   assign diff      = {1'b0, freq_q} - {1'b0, step_q};
   assign next_up   = (sum[32] || (sum[31:0] > stop_q)) ? stop_q : sum[31:0];
   assign next_dn   = (diff[32] || (diff[31:0] < stop_q)) ? stop_q : diff[31:0];
   assign next_freq = dir_up_q ? next_up : next_dn;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides everything except reset
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_go) begin
               state_d = StDwell;
            end
         end
         StDwell: begin
            if (abort) begin
               state_d = StIdle;
            end else if (expired && at_end && !loop_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy        = (state_q == StDwell);
      done        = (state_q == StDone);
      step_strobe = strobe_q;
      freq_set    = freq_q;
   end

   // Datapath next values: parameter capture, dwell countdown, frequency update
   always_comb begin
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      loop_d   = loop_q;
      dir_up_d = dir_up_q;
      cnt_d    = cnt_q;
      freq_d   = freq_q;
      strobe_d = 1'b0;
      if (start_go) begin
         start_d  = f_start;
         stop_d   = f_stop;
         step_d   = f_step;
         dwell_d  = dwell_in;
         loop_d   = loop_en;
         dir_up_d = (f_stop >= f_start);
         freq_d   = f_start;
         strobe_d = 1'b1;
         cnt_d    = dwell_in - DwellOne;
      end else if (state_q == StDwell && !abort) begin
         if (!expired) begin
            cnt_d = cnt_q - DwellOne;
         end else if (!at_end) begin
            freq_d   = next_freq;
            strobe_d = 1'b1;
            cnt_d    = dwell_q - DwellOne;
         end else if (loop_q) begin
            freq_d   = start_q;
            strobe_d = 1'b1;
            cnt_d    = dwell_q - DwellOne;
         end
      end else if (abort) begin
         cnt_d = '0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q  <= '0;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         loop_q   <= 1'b0;
         dir_up_q <= 1'b0;
         cnt_q    <= '0;
         freq_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         start_q  <= start_d;
         stop_q   <= stop_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
         loop_q   <= loop_d;
         dir_up_q <= dir_up_d;
         cnt_q    <= cnt_d;
         freq_q   <= freq_d;
         strobe_q <= strobe_d;
      end
   end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Testbench for freq_sweep_ctrl: directed and randomized sweeps checked against a
// list-of-values reference model built with plain integer arithmetic.
module tb_freq_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        loop_en;
   logic [31:0] f_start;
   logic [31:0] f_stop;
   logic [31:0] f_step;
   logic [31:0] dwell_cycles;
   logic [31:0] freq_set;
   logic        busy;
   logic        step_strobe;
   logic        done;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_vals[$];
   int          exp_dwell;

   freq_sweep_ctrl #(
      .CLKREF (32'd256_000_000),
      .DWELL_W(32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .loop_en     (loop_en),
      .f_start     (f_start),
      .f_stop      (f_stop),
      .f_step      (f_step),
      .dwell_cycles(dwell_cycles),
      .freq_set    (freq_set),
      .busy        (busy),
      .step_strobe (step_strobe),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: list of frequencies one sweep visits, from clamped integer stepping.
   function automatic void build(input logic [31:0] fs, input logic [31:0] fe,
                                 input logic [31:0] st, input logic [31:0] dw);
      longint v;
      longint nv;
      exp_vals.delete();
      v = longint'(fs);
      exp_vals.push_back(fs);
      while (v != longint'(fe) && st != 0) begin
         if (fe >= fs) begin
            nv = v + longint'(st);
            if (nv > longint'(fe)) nv = longint'(fe);
         end else begin
            nv = v - longint'(st);
            if (nv < longint'(fe)) nv = longint'(fe);
         end
         v = nv;
         exp_vals.push_back(v[31:0]);
      end
      exp_dwell = (dw == 0) ? 1 : int'(dw);
   endfunction

   task automatic scramble();
      f_start      = $urandom;
      f_stop       = $urandom;
      f_step       = $urandom;
      dwell_cycles = $urandom_range(0, 7);
      loop_en      = 1'($urandom);
   endtask

   task automatic launch(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [31:0] dw, input logic lp);
      build(fs, fe, st, dw);
      @(negedge clk);
      f_start      = fs;
      f_stop       = fe;
      f_step       = st;
      dwell_cycles = dw;
      loop_en      = lp;
      start        = 1'b1;
   endtask

   // Checks ncyc cycles of an active sweep; values repeat when the sweep loops.
   task automatic play(input int ncyc, input bit poke_start);
      int len;
      len = exp_vals.size();
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            scramble();
         end
         if (k == 2) start = 1'b0;
         chk("freq_set", freq_set, exp_vals[(k / exp_dwell) % len]);
         chk("step_strobe", 32'(step_strobe), 32'((k % exp_dwell) == 0));
         chk("busy", 32'(busy), 32'd1);
         chk("done", 32'(done), 32'd0);
         if (poke_start && k == 1 && ncyc > 3) start = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic finish_single();
      logic [31:0] last;
      last = exp_vals[exp_vals.size() - 1];
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_strobe", 32'(step_strobe), 32'd0);
      chk("done_freq", freq_set, last);
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_freq", freq_set, last);
   endtask

   task automatic single(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [31:0] dw, input bit poke);
      launch(fs, fe, st, dw, 1'b0);
      play(exp_vals.size() * exp_dwell, poke);
      finish_single();
   endtask

   // Looping sweep, aborted after ncyc checked cycles.
   task automatic loop_abort(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                             input logic [31:0] dw, input int ncyc);
      logic [31:0] held;
      launch(fs, fe, st, dw, 1'b1);
      play(ncyc, 1'b0);
      held  = exp_vals[((ncyc - 1) / exp_dwell) % exp_vals.size()];
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_strobe", 32'(step_strobe), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_freq", freq_set, held);
      @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);
      chk("abort_idle_done", 32'(done), 32'd0);
      chk("abort_idle_freq", freq_set, held);
   endtask

   initial begin
      logic [31:0] fs;
      logic [31:0] fe;
      logic [31:0] st;
      longint      range;
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      loop_en      = 1'b0;
      f_start      = '0;
      f_stop       = '0;
      f_step       = '0;
      dwell_cycles = '0;
      #12;
      chk("rst_freq", freq_set, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobe", 32'(step_strobe), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      single(32'd1000, 32'd1300, 32'd100, 32'd4, 1'b1);
      single(32'd1000, 32'd1250, 32'd100, 32'd2, 1'b0);
      single(32'd500, 32'd200, 32'd150, 32'd1, 1'b0);
      single(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 32'd3, 1'b0);
      single(32'h100, 32'h0, 32'h90, 32'd2, 1'b0);
      single(32'd5, 32'd8, 32'd1, 32'd0, 1'b0);
      single(32'd700, 32'd900, 32'd0, 32'd1, 1'b0);
      single(32'd42, 32'd42, 32'd7, 32'd2, 1'b0);

      loop_abort(32'd10, 32'd30, 32'd10, 32'd3, 13);

      for (int i = 0; i < 24; i++) begin
         fs = (i % 4 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 5000))) : $urandom;
         fe = (i % 4 == 1) ? 32'($urandom_range(0, 5000)) : $urandom;
         range = (fe >= fs) ? longint'(fe) - longint'(fs) : longint'(fs) - longint'(fe);
         st = 32'(range / longint'($urandom_range(1, 6))) + 32'($urandom_range(0, 3));
         if (i % 7 == 3) st = 32'd0;
         if (i % 3 == 2) begin
            launch(fs, fe, st, 32'($urandom_range(0, 4)), 1'b1);
            start = 1'b0;
            loop_abort(fs, fe, st, 32'(exp_dwell), $urandom_range(1, 40));
         end else begin
            single(fs, fe, st, 32'($urandom_range(0, 4)), 1'(i % 2));
         end
      end

      // Asynchronous reset in the middle of a dwell
      launch(32'd1000, 32'd1300, 32'd100, 32'd4, 1'b0);
      play(6, 1'b0);
      rst = 1'b1;
      #1;
      chk("arst_freq", freq_set, 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_strobe", 32'(step_strobe), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("after_rst_freq", freq_set, 32'd0);
         chk("after_rst_busy", 32'(busy), 32'd0);
         chk("after_rst_strobe", 32'(step_strobe), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
